// File: rtl/bsg_trace_word_gather.sv
// bsg_trace_word_gather
//
// Collects words_p consecutive payload words from a bsg_trace_replay stimulus
// channel into one wide packet and hands it to a downstream consumer through a
// 2-entry output buffer, so gathering continues while the consumer stalls and a
// steady one-word-per-cycle stream is sustained.
//
// Parameters
//   word_width_p  width of each input word
//   words_p       words per packet, 2..16
//
// Ports
//   clk_i    in   clock
//   reset_i  in   synchronous active-high reset
//   v_i      in   input word valid
//   data_i   in   input word
//   ready_o  out  word accepted this cycle when v_i & ready_o
//   v_o      out  packet valid (head of the output buffer)
//   data_o   out  packet, first-received word in the least significant slot
//   ready_i  in   consumer accepts packet this cycle when v_o & ready_i
//   flush_i  in   (only with BSG_TRACE_WORD_GATHER_FLUSH_EN) emit a partial
//                 packet, unfilled slots zero
//
// Optional feature macro: BSG_TRACE_WORD_GATHER_FLUSH_EN
//
// The file also holds bsg_trace_word_gather_checker, a non-synthesizable
// protocol checker for the input channel, meant for simulation only.

module bsg_trace_word_gather #(
  parameter int word_width_p = 32,
  parameter int words_p      = 3
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic [word_width_p-1:0]         data_i,
  output logic                            ready_o,
  output logic                            v_o,
  output logic [word_width_p*words_p-1:0] data_o,
  input  logic                            ready_i
`ifdef BSG_TRACE_WORD_GATHER_FLUSH_EN
  ,
  input  logic                            flush_i
`endif
);

  localparam int cnt_w = $clog2(words_p);
  localparam int pkt_w = word_width_p * words_p;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(words_p - 1);

  logic [cnt_w-1:0]                          count_r;
  logic [words_p-1:0][word_width_p-1:0]      slots_r;
  logic [1:0]                                occ_r;
  logic [pkt_w-1:0]                          head_r;
  logic [pkt_w-1:0]                          tail_r;

  logic                                      ready_s;
  logic                                      v_s;
  logic                                      accept_s;
  logic                                      complete_s;
  logic                                      deq_s;
  logic                                      enq_s;
  logic [cnt_w-1:0]                          count_after_s;
  logic [cnt_w-1:0]                          count_next_s;
  logic [1:0]                                occ_after_deq_s;
  logic [1:0]                                occ_next_s;
  logic [words_p-1:0][word_width_p-1:0]      pkt_s;
  logic [pkt_w-1:0]                          head_next_s;
  logic [pkt_w-1:0]                          tail_next_s;

`ifdef BSG_TRACE_WORD_GATHER_FLUSH_EN
  // A flush that finds the buffer full is remembered here; it blocks further
  // words so the partial packet cannot grow or complete while it waits.
  logic                                      flush_pend_r;
  logic                                      flush_req_s;
  logic                                      flush_fire_s;
  logic                                      flush_pend_next_s;
`endif

  // Handshake terms; ready depends on registered state only.
  always_comb begin
    ready_s = 1'b0;
    v_s     = 1'b0;
    if (reset_i) begin
      ready_s = 1'b0;
      v_s     = 1'b0;
    end else begin
      // Only the completing word needs buffer room.
      ready_s = (count_r != last_cnt) | (occ_r != 2'd2);
`ifdef BSG_TRACE_WORD_GATHER_FLUSH_EN
      ready_s = ready_s & ~flush_pend_r;
`endif
      v_s     = (occ_r != 2'd0);
    end
  end

  // Gather datapath: packet image, counter and buffer occupancy bookkeeping.
  always_comb begin
    accept_s        = v_i & ready_s;
    complete_s      = accept_s & (count_r == last_cnt);
    deq_s           = v_s & ready_i;
    count_after_s   = count_r;
    pkt_s           = '0;
    occ_after_deq_s = occ_r - {1'b0, deq_s};

    if (complete_s) begin
      count_after_s = '0;
    end else if (accept_s) begin
      count_after_s = count_r + cnt_w'(1);
    end else begin
      count_after_s = count_r;
    end

    // Slots at or beyond the fill point read as zero, so the gather registers
    // never need clearing and a flushed partial packet is zero-padded for free.
    for (int i = 0; i < words_p; i++) begin
      if (accept_s && (cnt_w'(i) == count_r)) begin
        pkt_s[i] = data_i;
      end else if (cnt_w'(i) < count_r) begin
        pkt_s[i] = slots_r[i];
      end else begin
        pkt_s[i] = '0;
      end
    end

`ifdef BSG_TRACE_WORD_GATHER_FLUSH_EN
    flush_req_s       = flush_i | flush_pend_r;
    // A word completing a full packet leaves count_after at zero, which
    // turns a simultaneous flush into a no-op.
    flush_fire_s      = flush_req_s & (count_after_s != '0) & (occ_after_deq_s != 2'd2);
    flush_pend_next_s = flush_req_s & (count_after_s != '0) & ~flush_fire_s;
    enq_s             = complete_s | flush_fire_s;
    count_next_s      = flush_fire_s ? '0 : count_after_s;
`else
    enq_s             = complete_s;
    count_next_s      = count_after_s;
`endif

    occ_next_s = occ_after_deq_s + {1'b0, enq_s};
  end

  // Output buffer next state: head is the oldest packet, tail the younger one.
  always_comb begin
    head_next_s = head_r;
    tail_next_s = tail_r;
    // Head only moves on dequeue when a younger packet exists, so after the
    // last packet leaves data_o keeps showing it.
    if (deq_s && (occ_r == 2'd2)) begin
      head_next_s = tail_r;
    end else begin
      head_next_s = head_r;
    end
    if (enq_s) begin
      if (occ_after_deq_s == 2'd0) begin
        head_next_s = pkt_s;
      end else begin
        tail_next_s = pkt_s;
      end
    end else begin
      tail_next_s = tail_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
      slots_r <= '0;
      occ_r   <= 2'd0;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      count_r <= count_next_s;
      occ_r   <= occ_next_s;
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      if (accept_s) begin
        slots_r[count_r] <= data_i;
      end
    end
  end

`ifdef BSG_TRACE_WORD_GATHER_FLUSH_EN
  // Pending-flush register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flush_pend_r <= 1'b0;
    end else begin
      flush_pend_r <= flush_pend_next_s;
    end
  end
`endif

  assign ready_o = ready_s;
  assign v_o     = v_s;
  assign data_o  = reset_i ? '0 : head_r;

endmodule


// bsg_trace_word_gather_checker
//
// Simulation-only input channel checker: once a word is offered it must stay
// offered with unchanged data until it is accepted.
//
// Ports: clk_i, reset_i, v_i, data_i, ready_o (all inputs, observed only).
module bsg_trace_word_gather_checker #(
  parameter int word_width_p = 32
) (
  input logic                    clk_i,
  input logic                    reset_i,
  input logic                    v_i,
  input logic [word_width_p-1:0] data_i,
  input logic                    ready_o
);

  property p_hold_until_accept;
    @(posedge clk_i) disable iff (reset_i)
      (v_i & ~ready_o) |=> (v_i & $stable(data_i));
  endproperty

  a_hold_until_accept: assert property (p_hold_until_accept)
    else $error("input word dropped or changed before acceptance");

endmodule
